uart_rx: RTL and testbench

- Asynchronous serial receiver; the receive-side counterpart of the existing uart_tx.
- Frame format: 8N1 by default, LSB first, idle-high line.
- Sits between an input pin (ui_in bit) and the user logic. Delivers each received byte with a one-cycle valid strobe and flags stop-bit (framing) errors.
- Uses the same BIT_RATE/PAYLOAD_BITS/CLK_HZ parameter set as uart_tx, so both ends share one configuration.

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line and enable in, byte/strobes/busy out.
interface uart_rx_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    uart_rxd;
   logic                    uart_rx_en;
   logic                    uart_rx_busy;
   logic                    uart_rx_valid;
   logic [PAYLOAD_BITS-1:0] uart_rx_data;
   logic                    uart_rx_frame_err;
   logic                    uart_rx_parity_err;

   modport master (
      output uart_rxd, uart_rx_en,
      input  uart_rx_busy, uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_parity_err
   );

   modport slave (
      input  uart_rxd, uart_rx_en,
      output uart_rx_busy, uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_parity_err
   );
endinterface

// File: rtl/uart_rx.sv
// Asynchronous serial receiver, 8N1 LSB first, mid-bit sampling from the synchronized start edge.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8,
   parameter int CLK_HZ       = 20_000_000
) (
   input  logic      clk,
   input  logic      reset,
   uart_rx_if.slave  rx
);
   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam int IDX_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        bit_idx;
   logic [PAYLOAD_BITS-1:0] sreg_p0;
   logic [PAYLOAD_BITS-1:0] data;
   logic                    rxd_p0, rxd_p1;
   logic                    rxs;
   logic                    busy, valid, frame_err;
`ifdef UART_RX_PARITY_EN
   logic                    par_ok, parity_err;
`endif

   // Stage p0/p1: two-flop synchronizer; idles high so reset never looks like a start edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxd_p0 <= 1'b1;
         rxd_p1 <= 1'b1;
      end else begin
         rxd_p0 <= rx.uart_rxd;
         rxd_p1 <= rxd_p0;
      end
   end

   assign rxs = rxd_p1;

   // Shift register: new bit enters at the MSB so the LSB-first byte lands in place
   always_ff @(posedge clk) begin
      if (state == DATA && cnt == CNT_FULL)
         sreg_p0 <= {rxs, sreg_p0[PAYLOAD_BITS-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         data      <= '0;
`ifdef UART_RX_PARITY_EN
         par_ok     <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         cnt <= cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (rx.uart_rx_en && !rxs) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
               end
            end
            DATA: begin
               if (cnt == CNT_FULL) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == IDX_LAST)
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == CNT_FULL) begin
                  cnt    <= '0;
                  par_ok <= (rxs == ^sreg_p0);
                  state  <= STOP;
               end
            end
`endif
            STOP: begin
               if (cnt == CNT_FULL) begin
                  cnt <= '0;
                  if (!rxs) begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     if (par_ok) begin
                        valid <= 1'b1;
                        data  <= sreg_p0;
                     end else begin
                        parity_err <= 1'b1;
                     end
`else
                     valid <= 1'b1;
                     data  <= sreg_p0;
`endif
                  end
               end
            end
            WAIT_HIGH: begin
               // A held-low (break) line must not spawn back-to-back bogus frames
               cnt <= '0;
               if (rxs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rx.uart_rx_busy      = busy;
   assign rx.uart_rx_valid     = valid;
   assign rx.uart_rx_data      = data;
   assign rx.uart_rx_frame_err = frame_err;
`ifdef UART_RX_PARITY_EN
   assign rx.uart_rx_parity_err = parity_err;
`else
   assign rx.uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; strobes are tallied by a monitor process.
module tb_uart_rx;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_valid = 0;
   int   n_ferr  = 0;
   int   n_perr  = 0;
   int   n_overlap = 0;

   uart_rx_if #(.PAYLOAD_BITS(8)) bus ();

   uart_rx #(
      .BIT_RATE(100_000),
      .PAYLOAD_BITS(8),
      .CLK_HZ(1_000_000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.uart_rx_valid)      n_valid <= n_valid + 1;
      if (bus.uart_rx_frame_err)  n_ferr  <= n_ferr + 1;
      if (bus.uart_rx_parity_err) n_perr  <= n_perr + 1;
      if ((32'(bus.uart_rx_valid) + 32'(bus.uart_rx_frame_err) + 32'(bus.uart_rx_parity_err)) > 1)
         n_overlap <= n_overlap + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      bus.uart_rxd = b;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(stop_b);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_badpar(input logic [7:0] d);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(~(^d));
      drive_bit(1'b1);
   endtask
`endif

   initial begin
      reset = 1'b1;
      bus.uart_rxd   = 1'b1;
      bus.uart_rx_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy",  32'(bus.uart_rx_busy), 0);
      check("reset_valid", 32'(bus.uart_rx_valid), 0);
      check("reset_data",  32'(bus.uart_rx_data), 0);
      check("reset_ferr",  32'(bus.uart_rx_frame_err), 0);
      check("reset_perr",  32'(bus.uart_rx_parity_err), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_busy", 32'(bus.uart_rx_busy), 0);

      // Basic receive
      send_frame(8'h55, 1'b1);
      check("rx55_count", n_valid, 1);
      check("rx55_data",  32'(bus.uart_rx_data), 32'h55);
      check("rx55_busy",  32'(bus.uart_rx_busy), 0);
      send_frame(8'hA3, 1'b1);
      check("rxA3_count", n_valid, 2);
      check("rxA3_data",  32'(bus.uart_rx_data), 32'hA3);
      check("rxA3_busy",  32'(bus.uart_rx_busy), 0);

      // False start: 3-cycle glitch
      bus.uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      bus.uart_rxd = 1'b1;
      @(negedge clk);
      check("glitch_busy_hi", 32'(bus.uart_rx_busy), 1);
      repeat (20) @(negedge clk);
      check("glitch_busy_lo", 32'(bus.uart_rx_busy), 0);
      check("glitch_valid",   n_valid, 2);
      check("glitch_ferr",    n_ferr, 0);
      check("glitch_data",    32'(bus.uart_rx_data), 32'hA3);

      // Framing error followed by a break
      send_frame(8'h3C, 1'b0);
      repeat (50) @(negedge clk);
      check("ferr_count", n_ferr, 1);
      check("ferr_valid", n_valid, 2);
      check("ferr_data",  32'(bus.uart_rx_data), 32'hA3);
      check("ferr_busy",  32'(bus.uart_rx_busy), 1);
      bus.uart_rxd = 1'b1;
      repeat (5) @(negedge clk);
      check("ferr_release_busy", 32'(bus.uart_rx_busy), 0);
      send_frame(8'h81, 1'b1);
      check("rx81_count", n_valid, 3);
      check("rx81_data",  32'(bus.uart_rx_data), 32'h81);

      // Disabled receiver ignores the line
      bus.uart_rx_en = 1'b0;
      send_frame(8'h12, 1'b1);
      check("dis_count", n_valid, 3);
      check("dis_data",  32'(bus.uart_rx_data), 32'h81);
      check("dis_busy",  32'(bus.uart_rx_busy), 0);

      // Back-to-back frames with no idle gap
      bus.uart_rx_en = 1'b1;
      send_frame(8'hF0, 1'b1);
      check("b2b_F0_data", 32'(bus.uart_rx_data), 32'hF0);
      send_frame(8'h0F, 1'b1);
      check("b2b_0F_data", 32'(bus.uart_rx_data), 32'h0F);
      check("b2b_count",   n_valid, 5);

      // Reset during bit 4 of 0x99
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(((8'h99 >> i) & 8'h01) != 0);
      bus.uart_rxd = 1'b1;
      repeat (5) @(negedge clk);
      check("pre_rst_busy", 32'(bus.uart_rx_busy), 1);
      reset = 1'b1;
      #1;
      check("rst_busy",  32'(bus.uart_rx_busy), 0);
      check("rst_data",  32'(bus.uart_rx_data), 0);
      check("rst_valid", 32'(bus.uart_rx_valid), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("post_rst_busy",  32'(bus.uart_rx_busy), 0);
      check("post_rst_valid", n_valid, 5);
      check("post_rst_ferr",  n_ferr, 1);
      send_frame(8'h42, 1'b1);
      check("rx42_count", n_valid, 6);
      check("rx42_data",  32'(bus.uart_rx_data), 32'h42);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1);
      check("par_ok_count", n_valid, 7);
      check("par_ok_data",  32'(bus.uart_rx_data), 32'h07);
      send_frame_badpar(8'h07);
      check("par_bad_perr",  n_perr, 1);
      check("par_bad_valid", n_valid, 7);
      check("par_bad_data",  32'(bus.uart_rx_data), 32'h07);
`else
      check("no_parity_err", n_perr, 0);
`endif
      check("strobe_overlap", n_overlap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
